fetch_stage: RTL

Instruction-fetch front end that sits directly upstream of `decode_stage`. It owns the PC and issues word-aligned requests to an instruction memory over a request/response handshake. It buffers returned instructions in a small FIFO and presents them to decode with a valid/stall handshake. It also handles front-panel PC load and branch/jump redirects from execution, including discarding stale in-flight responses.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one word at a time from imem and queues the returned instructions for decode_stage.
// Build option: define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        SYS_load,
  input  logic [7:0]  SYS_pc_val,
  input  logic        EX_redirect,
  input  logic [31:0] EX_redirect_pc,
  input  logic        D_stall,
  output logic        F_imem_req,
  output logic [31:0] F_imem_addr,
  input  logic        F_imem_ready,
  input  logic        F_imem_rvalid,
  input  logic [31:0] F_imem_rdata,
  output logic        F_valid,
  output logic [31:0] F_instruction,
  output logic [31:0] F_pc,
  output logic [31:0] F_pc_plus4
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_instr [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];

  logic        redirect, accept, rsp_ok, empty, push, pop;
  logic [31:0] target, rsp_pc, head_instr, head_pc;

  assign redirect = SYS_load || EX_redirect;
  assign target   = SYS_load ? {24'h0, SYS_pc_val & 8'hFC} : (EX_redirect_pc & ~32'h3);
  assign empty    = (count_q == '0);

  assign F_imem_req  = (state_q == FETCH) && (count_q < FULL_CNT) && !SYS_reset;
  assign F_imem_addr = pc_q;
  assign accept      = F_imem_req && F_imem_ready;

  // Responses arriving during a redirect belong to the old path and are dropped.
  assign rsp_ok     = (state_q == WAIT) && F_imem_rvalid && !redirect;
  assign rsp_pc     = pc_q - 32'd4;
  assign head_instr = buf_instr[rd_ptr_q];
  assign head_pc    = buf_pc[rd_ptr_q];

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass        = empty && rsp_ok;
  assign F_valid       = !empty || bypass;
  assign F_instruction = bypass ? F_imem_rdata : (empty ? 32'h0 : head_instr);
  assign F_pc          = bypass ? rsp_pc : (empty ? 32'h0 : head_pc);
  assign pop           = !empty && !D_stall;
  assign push          = rsp_ok && !(bypass && !D_stall);
`else
  assign F_valid       = !empty;
  assign F_instruction = empty ? 32'h0 : head_instr;
  assign F_pc          = empty ? 32'h0 : head_pc;
  assign pop           = F_valid && !D_stall;
  assign push          = rsp_ok;
`endif

  assign F_pc_plus4 = F_valid ? (F_pc + 32'd4) : 32'h0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      pc_d     = target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // Drain only if a response is still owed after this edge.
      state_d  = (accept || ((state_q != FETCH) && !F_imem_rvalid)) ? DRAIN : FETCH;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      case (state_q)
        FETCH:       if (accept) state_d = WAIT;
        WAIT, DRAIN: if (F_imem_rvalid) state_d = FETCH;
        default:     state_d = FETCH;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + (PTR_W)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W)'(1);
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(negedge SYS_clk) begin
    if (SYS_reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC & ~32'h3;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(negedge SYS_clk) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= F_imem_rdata;
      buf_pc[wr_ptr_q]    <= rsp_pc;
    end
  end

endmodule
